// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit, 7-segment display with one shared decoder.
// Each digit slot is BLANK dark cycles followed by DIV-BLANK lit cycles.
module seg_scan_ctrl #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_blank,
  output logic [3:0] dec_data,
  output logic [3:0] digit_en,
  output logic [1:0] scan_idx,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    S_OFF,
    S_BLANK,
    S_SHOW
  } state_t;

  typedef struct packed {
    logic       blank;
    logic [3:0] code;
  } entry_t;

  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
  localparam logic [15:0] SHOW_LAST  = 16'(DIV - BLANK - 1);

  state_t      state;
  logic [15:0] cnt;
  entry_t      buffer [4];

  // NOTE: the digit buffer is reset on purpose -- every digit must come up
  // suppressed, and it is only four entries, so it stays in flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) buffer[i] <= '{blank: 1'b1, code: 4'd0};
    end else if (wr_en) begin
      buffer[wr_addr] <= '{blank: wr_blank, code: wr_data};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state      <= S_OFF;
      cnt        <= '0;
      scan_idx   <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        S_OFF: begin
          state <= S_BLANK;
          cnt   <= '0;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= S_SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state      <= S_BLANK;
            cnt        <= '0;
            scan_idx   <= scan_idx + 2'd1;
            frame_tick <= (scan_idx == 2'd3);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= S_OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded straight from registered state so a buffer write shows up on the very next cycle.
  assign dec_data = buffer[scan_idx].code;

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    digit_en = 4'b0000;
    if (state == S_SHOW && !buffer[scan_idx].blank) digit_en = 4'b0001 << scan_idx;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, every cycle
// compared against a frame-position model of the scan.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_blank = 1'b0;
  logic [3:0] dec_data;
  logic [3:0] digit_en;
  logic [1:0] scan_idx;
  logic       frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: whether scanning is active, cycles since it became active, and the buffer.
  bit       m_on = 1'b0;
  int       p = 0;
  bit [4:0] mbuf [4] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000};

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_blank   (wr_blank),
    .dec_data   (dec_data),
    .digit_en   (digit_en),
    .scan_idx   (scan_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_on = 1'b0;
      p    = 0;
      for (int i = 0; i < 4; i++) mbuf[i] = 5'b10000;
    end else begin
      if (wr_en) mbuf[wr_addr] = {wr_blank, wr_data};
      if (!en) begin
        m_on = 1'b0;
        p    = 0;
      end else if (!m_on) begin
        m_on = 1'b1;
        p    = 0;
      end else begin
        p++;
      end
    end
  endtask

  task automatic check_model();
    int       idx;
    bit       lit;
    bit [3:0] exp_en;
    idx    = m_on ? (p / DIV) % 4 : 0;
    lit    = m_on && ((p % DIV) >= BLANK) && !mbuf[idx][4];
    exp_en = lit ? (4'b0001 << idx) : 4'b0000;
    chk("scan_idx", {2'b00, scan_idx}, 4'(idx));
    chk("digit_en", digit_en, exp_en);
    chk("dec_data", dec_data, mbuf[idx][3:0]);
    chk("frame_tick", {3'b000, frame_tick}, {3'b000, (m_on && p > 0 && (p % FRAME) == 0)});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic write(input int a, input int d, input bit b);
    wr_en    = 1'b1;
    wr_addr  = 2'(a);
    wr_data  = 4'(d);
    wr_blank = b;
    step();
    wr_en    = 1'b0;
  endtask

  // Advance until the model sits at a given digit slot and slot offset.
  task automatic wait_phase(input string tag, input int slot, input int off);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_on && ((p / DIV) % 4) == slot && (p % DIV) == off) return;
      step();
    end
    n_cmp++;
    n_bad++;
    $error("FAIL %s: phase slot %0d offset %0d not reached, observed p=%0d", tag, slot, off, p);
  endtask

  initial begin
    int ticks;

    // Reset state
    #2;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_digit_en", digit_en, 4'b0000);
    chk("reset_dec_data", dec_data, 4'h0);

    // Load 1,2,3,4 and scan two full frames
    for (int i = 0; i < 4; i++) write(i, i + 1, 1'b0);
    en = 1'b1;
    step();
    for (int i = 0; i < 2 * FRAME + 4; i++) step();

    // Frame tick spacing over three frames
    ticks = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_tick) ticks++;
    end
    chk("tick_count_3_frames", 4'(ticks), 4'd3);

    // Blank entry 2: slot stays dark, decoder still sees code 3
    write(2, 3, 1'b1);
    wait_phase("blank2", 2, BLANK + 1);
    chk("blank2_digit_en", digit_en, 4'b0000);
    chk("blank2_dec_data", dec_data, 4'h3);
    wait_phase("blank2_end", 3, 0);
    write(2, 3, 1'b0);

    // Rewrite the digit being shown
    wait_phase("live_write", 1, BLANK + 1);
    write(1, 9, 1'b0);
    chk("live_write_dec_data", dec_data, 4'h9);
    chk("live_write_digit_en", digit_en, 4'b0010);
    wait_phase("live_write_end", 2, 0);

    // Write landing on the slot-advance edge to the next digit
    wait_phase("adv_write", 2, DIV - 1);
    write(3, 5, 1'b0);
    for (int i = 0; i < DIV; i++) step();

    // Drop enable mid-show of digit 3, then resume
    wait_phase("en_drop", 3, BLANK + 2);
    en = 1'b0;
    step();
    chk("en_drop_digit_en", digit_en, 4'b0000);
    chk("en_drop_scan_idx", {2'b00, scan_idx}, 4'd0);
    chk("en_drop_tick", {3'b000, frame_tick}, 4'd0);
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    for (int i = 0; i < DIV + 2; i++) step();

    // Reset mid-show with a simultaneous write: write is lost
    wait_phase("rst_show", 1, BLANK + 2);
    rst      = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 2'd0;
    wr_data  = 4'hA;
    wr_blank = 1'b0;
    step();
    rst   = 1'b0;
    wr_en = 1'b0;
    chk("rst_show_digit_en", digit_en, 4'b0000);
    chk("rst_show_dec_data", dec_data, 4'h0);
    chk("rst_show_scan_idx", {2'b00, scan_idx}, 4'd0);
    wait_phase("rst_readback", 0, BLANK + 1);
    chk("rst_readback_digit_en", digit_en, 4'b0000);
    chk("rst_readback_dec_data", dec_data, 4'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 99) >= 2);
      wr_en    = ($urandom_range(0, 4) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 4'($urandom_range(0, 15));
      wr_blank = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: clock cycles per digit slot, BLANK plus display time; legal range BLANK+2 .. 65535.
REQ-002 Parameter BLANK, default 4: inter-digit blanking cycles; legal range 1 .. DIV-2.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous to clk and active-high.
REQ-005 en  in  1  scan enable; 0 turns display off.
REQ-006 wr_en  in  1  write strobe for the digit buffer.
REQ-007 wr_addr  in  2  digit index 0..3 to write.
REQ-008 wr_data  in  4  digit code, passed unchanged to the shared 7-seg decoder.
REQ-009 wr_blank  in  1  written together with wr_data; 1 = digit suppressed.
REQ-010 dec_data  out  4  code driven to the single shared decoder data input.
REQ-011 digit_en  out  4  one-hot active-high digit select; bit i = digit i.
REQ-012 scan_idx  out  2  digit currently scanned.
REQ-013 frame_tick  out  1  one-cycle pulse at the end of the digit-3 slot.

Function
REQ-014 Buffer: 4 entries of {blank, code[3:0]}; wr_en=1 writes entry wr_addr at the clock edge; the new value is visible on outputs from the next cycle.
REQ-015 dec_data SHALL equal buffer[scan_idx].code every cycle (combinational read of registered state), including in OFF and BLANK states.
REQ-016 FSM states: OFF, BLANK, SHOW; state and slot counter are registered.
REQ-017 OFF: digit_en=0, scan_idx=0, counter=0; en=1 -> BLANK with counter=0.
REQ-018 BLANK: digit_en=0; after exactly BLANK cycles -> SHOW, counter cleared.
REQ-019 SHOW: digit_en=onehot(scan_idx) if buffer[scan_idx].blank=0, else 0000; after exactly DIV-BLANK cycles -> BLANK with scan_idx+1, wrapping 3->0.
REQ-020 frame_tick SHALL be 1 for exactly the one cycle after the SHOW->BLANK transition from scan_idx=3 (i.e. first BLANK cycle of digit 0), else 0.
REQ-021 en=0 sampled in any state -> OFF next cycle; digit_en=0 from that cycle; scan_idx=0; no frame_tick.
REQ-022 digit_en SHALL never have more than one bit set, and SHALL be 0000 for at least BLANK cycles between any two different digits.
REQ-023 Write to the digit being shown: dec_data and digit_en (blank bit) change the next cycle; the slot timing is unaffected.
REQ-024 Write coinciding with a slot advance: the write completes; the following BLANK state presents the updated entry if wr_addr equals the new scan_idx.
REQ-025 Counter width: 16 bits; no wrap occurs within a slot for legal parameters.

Reset
REQ-026 rst=1 sampled at a clock edge: state=OFF, counter=0, scan_idx=0, digit_en=0000, frame_tick=0, all buffer entries={blank=1, code=0}; hence dec_data=0.
REQ-027 rst takes priority over en and wr_en in the same cycle; the write is discarded.
REQ-028 rst asserted mid-SHOW: the outputs above SHALL hold from the next cycle; scanning restarts at digit 0 only after rst=0 and en=1.

Verification (DIV=8, BLANK=2)
REQ-029 Reset, then write digits 0..3 = 1,2,3,4 with blank=0, then en=1 -> digit_en 0000 for 2 cycles, 0001 for 6 cycles with dec_data=1, 0000 for 2 cycles, then 0010 with dec_data=2; sequence continues through 1000 and wraps to 0001.
REQ-030 Continuous scan -> frame_tick high every 32 cycles, one cycle wide, coincident with the first BLANK cycle of digit 0.
REQ-031 Entry 2 written with blank=1 -> digit_en stays 0000 throughout the digit-2 slot; slot length is still 8 cycles; dec_data=3 during that slot.
REQ-032 During SHOW of digit 1, write addr 1 data 9 -> dec_data=9 on the next cycle; digit_en stays 0010; slot ends on schedule.
REQ-033 en dropped mid-SHOW of digit 3 -> next cycle digit_en=0000, scan_idx=0, no frame_tick; en raised again -> 2 blank cycles, then digit 0 is shown.
REQ-034 rst pulsed mid-SHOW with a simultaneous wr_en -> all outputs at reset values next cycle; the written entry reads back as blank=1, code=0.
